// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Brief    : Request/control bundle between the core pipeline and the
//            stall/flush controller.
// Revision : 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int SW         = $clog2(NUM_STAGES)
);
    logic [NUM_STAGES-1:0] stall_req;
    logic [NUM_STAGES-1:0] flush_req;
    logic                  halt_req;

    logic                  pc_stall;
    logic                  pc_flush;
    logic [SW-1:0]         redirect_stage;
    logic [NUM_STAGES-2:0] reg_stall;
    logic [NUM_STAGES-2:0] reg_flush;
    logic [NUM_STAGES-2:0] stage_valid;
    logic                  halt_ack;

    logic [31:0]           perf_stall_cycles;
    logic [31:0]           perf_flush_count;
    logic [31:0]           perf_bubble_count;

    // Pipeline side: raises requests, consumes strobes
    modport master (
        output stall_req, flush_req, halt_req,
        input  pc_stall, pc_flush, redirect_stage, reg_stall, reg_flush,
               stage_valid, halt_ack,
               perf_stall_cycles, perf_flush_count, perf_bubble_count
    );

    // Controller side
    modport slave (
        input  stall_req, flush_req, halt_req,
        output pc_stall, pc_flush, redirect_stage, reg_stall, reg_flush,
               stage_valid, halt_ack,
               perf_stall_cycles, perf_flush_count, perf_bubble_count
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : N-stage pipeline stall/flush controller with valid tracking and
//            halt/drain handshake. Optional perf counters: PIPE_CTRL_PERF_EN.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int SW         = $clog2(NUM_STAGES)
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int c_NUM_REGS = NUM_STAGES - 1;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_halt_ack;
    logic [c_NUM_REGS-1:0] r_stage_valid;

    logic [NUM_STAGES-1:0] w_hold;
    logic                  w_hold_acc;
    logic                  w_flush_any;
    logic                  w_flush_held;
    logic [SW-1:0]         w_flush_idx;
    logic                  w_eff_flush;
    logic                  w_run;
    logic                  w_pc_stall;
    logic [c_NUM_REGS-1:0] w_reg_stall;
    logic [c_NUM_REGS-1:0] w_reg_flush;
    logic [c_NUM_REGS-1:0] w_valid_src;
    logic [c_NUM_REGS-1:0] w_valid_nxt;
    logic                  w_unused_flush0;

    // Stage 0 cannot redirect the PC
    assign w_unused_flush0 = bus.flush_req[0];

    assign w_run = (r_state == S_RUN);

    // A stall in stage i freezes stage i and everything younger
    always_comb begin
        w_hold_acc = 1'b0;
        w_hold     = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            w_hold_acc = w_hold_acc | bus.stall_req[i];
            w_hold[i]  = w_hold_acc;
        end
    end

    // Ascending scan so the oldest requester wins
    always_comb begin
        w_flush_any  = 1'b0;
        w_flush_held = 1'b0;
        w_flush_idx  = '0;
        for (int i = 1; i < NUM_STAGES; i++) begin
            if (bus.flush_req[i]) begin
                w_flush_any  = 1'b1;
                w_flush_held = w_hold[i];
                w_flush_idx  = SW'(i);
            end
        end
    end

    assign w_eff_flush = w_flush_any & ~w_flush_held;
    assign w_pc_stall  = ~w_eff_flush & (w_hold[0] | ~w_run);

    always_comb begin
        w_reg_stall = '0;
        w_reg_flush = '0;
        for (int r = 1; r < NUM_STAGES; r++) begin
            if (w_eff_flush && (r <= int'(w_flush_idx))) begin
                w_reg_flush[r-1] = 1'b1;
            end else if (w_hold[r]) begin
                w_reg_stall[r-1] = 1'b1;
            end else if (w_hold[r-1]) begin
                w_reg_flush[r-1] = 1'b1;
            end
        end
        // Fetch is stopped outside RUN: keep new work out of register 1
        if (!w_run && !w_hold[1]) begin
            w_reg_flush[0] = 1'b1;
        end
    end

    // Register 1 is fed by fetch, which only produces work while running
    assign w_valid_src = {r_stage_valid[c_NUM_REGS-2:0], w_run};

    always_comb begin
        w_valid_nxt = r_stage_valid;
        for (int r = 0; r < c_NUM_REGS; r++) begin
            if (w_reg_flush[r]) begin
                w_valid_nxt[r] = 1'b0;
            end else if (!w_reg_stall[r]) begin
                w_valid_nxt[r] = w_valid_src[r];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage_valid <= '0;
        end else begin
            r_stage_valid <= w_valid_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_RUN;
            r_halt_ack <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_halt_ack <= 1'b0;
                    if (bus.halt_req) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!bus.halt_req) begin
                        r_state    <= S_RUN;
                        r_halt_ack <= 1'b0;
                    end else if (r_stage_valid == '0) begin
                        r_state    <= S_HALTED;
                        r_halt_ack <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (!bus.halt_req) begin
                        r_state    <= S_RUN;
                        r_halt_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_RUN;
                    r_halt_ack <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_stall       = w_pc_stall;
    assign bus.pc_flush       = w_eff_flush;
    assign bus.redirect_stage = w_eff_flush ? w_flush_idx : '0;
    assign bus.reg_stall      = w_reg_stall;
    assign bus.reg_flush      = w_reg_flush;
    assign bus.stage_valid    = r_stage_valid;
    assign bus.halt_ack       = r_halt_ack;

`ifdef PIPE_CTRL_PERF_EN
    logic        w_bubble;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_bubble;

    // Only bubbles from an older-stage hold count, not flushes or fetch stop
    always_comb begin
        w_bubble = 1'b0;
        for (int r = 1; r < NUM_STAGES; r++) begin
            if (!(w_eff_flush && (r <= int'(w_flush_idx))) && !w_hold[r] && w_hold[r-1]) begin
                w_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_stall  <= '0;
            r_perf_flush  <= '0;
            r_perf_bubble <= '0;
        end else begin
            if (w_pc_stall && w_run && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_eff_flush && (r_perf_flush != 32'hFFFF_FFFF)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
            if (w_bubble && (r_perf_bubble != 32'hFFFF_FFFF)) begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
        end
    end

    assign bus.perf_stall_cycles = r_perf_stall;
    assign bus.perf_flush_count  = r_perf_flush;
    assign bus.perf_bubble_count = r_perf_bubble;
`else
    assign bus.perf_stall_cycles = 32'd0;
    assign bus.perf_flush_count  = 32'd0;
    assign bus.perf_bubble_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline stall/flush controller for the N-stage RISC-V core. It replaces the fixed 5-stage hazard/branch priority logic and the valid tracking in the CPU top. It takes per-stage stall and redirect requests and produces per-pipeline-register stall/flush strobes and PC control. It tracks per-register valid bits and provides a halt/drain handshake that empties the pipeline for debug or program load.

Parameters:
NUM_STAGES, 5, number of pipeline stages (stage 0 = IF/PC, stage NUM_STAGES-1 = WB); legal range 3..8.
SW, $clog2(NUM_STAGES), width of the redirect stage index.

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
stall_req  input  NUM_STAGES  bit i: stage i cannot advance this cycle
flush_req  input  NUM_STAGES  bit i: stage i redirects the PC (mispredict/jump); bit 0 ignored
halt_req  input  1  level request to stop fetch and drain
pc_stall  output  1  hold PC
pc_flush  output  1  load redirect target into PC
redirect_stage  output  SW  index of the winning flush stage (0 when none)
reg_stall  output  NUM_STAGES-1  bit r-1: pipeline register r (feeding stage r) holds
reg_flush  output  NUM_STAGES-1  bit r-1: register r loads a bubble (NOP/zero)
stage_valid  output  NUM_STAGES-1  registered valid of register r
halt_ack  output  1  registered; pipeline empty and fetch stopped
perf_stall_cycles, perf_flush_count, perf_bubble_count  output  32 each  see Optional Feature

Behaviour:
- Reset (async, reset_n=0): stage_valid=0, halt_ack=0, FSM=RUN, perf counters=0. With all inputs 0, every combinational output is 0.
- hold[i] = OR of stall_req[NUM_STAGES-1:i]. An older stage stall freezes all younger stages.
- Flush arbitration: f = highest i≥1 with flush_req[i]=1. eff_flush = flush present and !hold[f].
  - A held flushing stage defers its flush. The requester keeps flush_req asserted while held.
  - The oldest flush wins. redirect_stage = f when eff_flush, otherwise 0.
- Per register r (1..NUM_STAGES-1), priority order:
  1. eff_flush and r≤f: reg_flush=1.
  2. hold[r]: reg_stall=1.
  3. hold[r-1] (bubble insert): reg_flush=1.
  4. Otherwise: load.
  - reg_stall and reg_flush are never both 1.
- Flush beats younger-stage stall. Example: load-use stall_req[1] with flush_req[2] gives a flush and no stall.
- PC: pc_flush = eff_flush. pc_stall = !eff_flush and (hold[0] or FSM≠RUN).
- Additional rule: when FSM≠RUN and !hold[1], reg_flush bit0 = 1 (no new fetch enters the pipeline).
- stage_valid[r] next value:
  - 0 on reg_flush.
  - Held on reg_stall.
  - Otherwise the source value: r=1 takes (FSM==RUN); r>1 takes stage_valid[r-1].
- FSM (registered):
  - RUN: halt_req → DRAIN.
  - DRAIN: !halt_req → RUN. Otherwise, if stage_valid all 0 → HALTED.
  - HALTED: !halt_req → RUN.
  - halt_ack = (FSM==HALTED).
- Flushes during DRAIN/HALTED still assert pc_flush, so the PC is correct on resume.
- Reset mid-drain returns the FSM to RUN with halt_ack=0.

Optional Feature:
Macro PIPE_CTRL_PERF_EN.
- Defined:
  - perf_stall_cycles increments each cycle pc_stall=1 and FSM==RUN.
  - perf_flush_count increments per eff_flush cycle.
  - perf_bubble_count increments per cycle with any bubble-insert (rule 3) flush.
  - All counters are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Not defined: the three ports are tied to 0 and no counter flops are generated.

Test Plan:
- Load-use: NUM_STAGES=5, pipeline full, stall_req=5'b00010 for 1 cycle → pc_stall=1, reg_stall=4'b0001, reg_flush=4'b0010. Next cycle stage_valid=4'b1101.
- Flush beats younger stall: stall_req=5'b00010, flush_req=5'b00100 → pc_flush=1, pc_stall=0, redirect_stage=2, reg_flush=4'b0011, reg_stall=0.
- Deferred flush: stall_req[3]=1 for 3 cycles with flush_req[2] held → pc_flush=0, reg_stall=4'b0111, reg_flush=4'b1000 for those cycles. The cycle stall_req drops → pc_flush=1, reg_flush=4'b0011.
- Double flush: flush_req=5'b01100 → redirect_stage=3, reg_flush=4'b0111.
- Halt: full pipeline, halt_req=1 → stage_valid reaches 0 after 5 edges, halt_ack=1 at the 6th edge. Drop halt_req → halt_ack=0 next edge, and stage_valid[0]=1 one edge later.
- Async reset during DRAIN → immediately stage_valid=0, halt_ack=0. After release with PIPE_CTRL_PERF_EN defined, perf counters read 0.
